nv_nvdla_csc_pp_status: RTL and testbench
=========================================

NV_NVDLA_CSC_PP_STATUS -- requirements
Module: NV_NVDLA_CSC_pp_status

Interface
REQ-001 SHALL have port nvdla_core_clk, input, 1, core clock; all state is updated on its rising edge.
REQ-002 SHALL have port nvdla_core_rstn, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port producer, input, 1, register group currently selected by software for writes.
REQ-004 SHALL have port op_en_wr, input, 1, single-cycle pulse: software write to D_OP_ENABLE of group "producer".
REQ-005 SHALL have port op_en_wr_data, input, 1, value carried by that write.
REQ-006 SHALL have port dp_done, input, 1, single-cycle pulse: datapath finished the running layer.
REQ-007 SHALL have port consumer, output, 1, group the engine executes now or will execute next.
REQ-008 SHALL have port status_0, output, 2, status of group 0: 0=IDLE, 1=RUNNING, 2=PENDING; 3 never driven.
REQ-009 SHALL have port status_1, output, 2, status of group 1, same encoding as status_0.
REQ-010 SHALL have port reg_op_en, output, 2, per-group op-enable flags, bit N for group N.
REQ-011 SHALL have port op_start, output, 1, single-cycle pulse launching a layer.
REQ-012 SHALL have port op_grp, output, 1, group whose fields the datapath uses; equals consumer.
REQ-013 SHALL have port done_intr, output, 2, single-cycle completion pulse, bit N for group N.

Function
REQ-014 SHALL set reg_op_en[producer] one cycle after op_en_wr with op_en_wr_data=1.
REQ-015 SHALL clear reg_op_en[producer] on op_en_wr with data=0 only when that group is not RUNNING; otherwise the write is ignored (no abort).
REQ-016 SHALL implement FSM states IDLE, START, RUN.
REQ-017 IDLE SHALL go to START on the cycle after reg_op_en[consumer]=1 is observed, else stay in IDLE.
REQ-018 START SHALL last exactly one cycle, assert op_start during it, then go to RUN.
REQ-019 RUN SHALL hold until dp_done=1; on that edge it SHALL clear reg_op_en[consumer], pulse done_intr[consumer] for one cycle, toggle consumer and return to IDLE.
REQ-020 SHALL sample dp_done only in RUN; a dp_done in IDLE or START has no effect.
REQ-021 status_N SHALL be RUNNING when state is START or RUN and consumer=N; PENDING when reg_op_en[N]=1 and not RUNNING; IDLE otherwise. These outputs SHALL be registered and change on the same edge as the state/op_en they reflect.
REQ-022 Write-to-enable latency: op_en_wr at edge t gives reg_op_en at t+1, START (op_start=1) at t+2 and RUN at t+3, when idle with consumer=producer.
REQ-023 Back-to-back: when the other group is PENDING at done, SHALL give IDLE for exactly one cycle, then START on that group; no cycle SHALL have two groups RUNNING.
REQ-024 Simultaneous set and clear: when an op_en_wr data=1 to group N and the done clear of group N occur on the same edge, the set SHALL win (reg_op_en[N]=1, status_N=PENDING), and done_intr[N] SHALL still pulse.
REQ-025 An op_en_wr to a group that is not consumer SHALL never start it before the consumer group completes; order is strictly alternating 0,1,0,1.
REQ-026 op_grp SHALL equal consumer at all times and SHALL be stable from START through the dp_done edge.

Reset
REQ-027 On nvdla_core_rstn low, regardless of state, SHALL force: state=IDLE, consumer=0, reg_op_en=2'b00, status_0=status_1=0, op_start=0, done_intr=2'b00.
REQ-028 Reset during RUN SHALL abandon the layer; no done_intr after release, and a later dp_done in IDLE SHALL be ignored.

Verification
REQ-029 Single layer: producer=0, op_en_wr=1/data=1 at t -> reg_op_en=01 at t+1, status_0=2 at t+1, op_start=1 at t+2, status_0=1; dp_done -> done_intr=01, consumer=1, status_0=0.
REQ-030 Ping-pong: enable group 0 then group 1 while 0 runs -> status_1=2; on dp_done of group 0, op_start for group 1 two cycles later, op_grp=1; second dp_done gives done_intr=10 and consumer=0.
REQ-031 Out-of-order enable: producer=1 enable only group 1 while consumer=0 -> no op_start, status_1=2 indefinitely; then enable group 0 -> group 0 runs first.
REQ-032 Collision: running group 0, op_en_wr data=1 to group 0 on the same edge as dp_done -> reg_op_en[0]=1, status_0=2, done_intr=01, consumer=1.
REQ-033 Ignored events: dp_done during IDLE and during START -> no state change; op_en data=0 to the RUNNING group -> reg_op_en unchanged.
REQ-034 Reset in RUN: assert nvdla_core_rstn=0 mid-layer -> all outputs 0 immediately (asynchronous); after release a dp_done produces no done_intr.

Source files
------------

// File: rtl/nv_nvdla_csc_pp_status.sv
// ============================================================================
// nv_nvdla_csc_pp_status
//
// Ping-pong register-group status tracker for the convolution sequencer.
// Software programs one of two register groups (selected by "producer") and
// arms it by writing D_OP_ENABLE. The engine executes groups strictly in
// alternating order (0,1,0,1,...). The group that runs now, or runs next, is
// "consumer". A small FSM (IDLE -> START -> RUN) launches a layer with a
// one-cycle op_start pulse. It waits for dp_done, then retires the group and
// hands over to the other one.
//
// Ports
//   nvdla_core_clk   in   1  core clock, rising edge
//   nvdla_core_rstn  in   1  asynchronous, active-low reset
//   producer         in   1  group targeted by software writes
//   op_en_wr         in   1  pulse: D_OP_ENABLE write to group "producer"
//   op_en_wr_data    in   1  data carried by that write
//   dp_done          in   1  pulse: datapath finished the running layer
//   consumer         out  1  group executing now / next
//   status_0         out  2  group 0 status: 0=IDLE 1=RUNNING 2=PENDING
//   status_1         out  2  group 1 status, same encoding
//   reg_op_en        out  2  per-group op-enable flags
//   op_start         out  1  pulse launching a layer
//   op_grp           out  1  group whose fields the datapath uses (=consumer)
//   done_intr        out  2  one-cycle completion pulse per group
// ============================================================================
module nv_nvdla_csc_pp_status (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       producer,
    input  logic       op_en_wr,
    input  logic       op_en_wr_data,
    input  logic       dp_done,
    output logic       consumer,
    output logic [1:0] status_0,
    output logic [1:0] status_1,
    output logic [1:0] reg_op_en,
    output logic       op_start,
    output logic       op_grp,
    output logic [1:0] done_intr
);

    // FSM encoding. The value 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Per-group status encoding. The value 2'd3 is never produced.
    localparam logic [1:0] STAT_IDLE    = 2'd0;
    localparam logic [1:0] STAT_RUNNING = 2'd1;
    localparam logic [1:0] STAT_PENDING = 2'd2;

    logic [1:0] state_q,     state_d;
    logic       consumer_q,  consumer_d;
    logic [1:0] reg_op_en_q, reg_op_en_d;
    logic [1:0] status_0_q,  status_0_d;
    logic [1:0] status_1_q,  status_1_d;
    logic       op_start_q,  op_start_d;
    logic [1:0] done_intr_q, done_intr_d;

    logic       done_fire;
    logic       producer_running;
    logic       next_busy;

    // Sequencing FSM and consumer pointer.
    // IDLE waits for the consumer group's enable flag and then launches it.
    // START is a single launch cycle. RUN waits for dp_done. Only RUN looks at
    // dp_done, so a stray done pulse in IDLE or START is dropped. On
    // completion the consumer pointer flips. That flip is what enforces
    // strict 0,1,0,1 ordering: an enabled group that is not the consumer just
    // sits at PENDING.
    always_comb begin
        state_d    = state_q;
        consumer_d = consumer_q;
        done_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reg_op_en_q[consumer_q]) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dp_done) begin
                    done_fire  = 1'b1;
                    state_d    = ST_IDLE;
                    consumer_d = ~consumer_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Op-enable flags.
    // Completion clears the retiring group first. A software write is applied
    // afterwards, so a set that lands on the same edge as the completion
    // clear wins and re-arms the group. A clear write aimed at the group
    // currently in START/RUN is ignored. Layers cannot be aborted this way.
    always_comb begin
        reg_op_en_d      = reg_op_en_q;
        producer_running = ((state_q == ST_START) || (state_q == ST_RUN)) &&
                           (consumer_q == producer);
        if (done_fire) begin
            reg_op_en_d[consumer_q] = 1'b0;
        end
        if (op_en_wr) begin
            if (op_en_wr_data) begin
                reg_op_en_d[producer] = 1'b1;
            end else if (!producer_running) begin
                reg_op_en_d[producer] = 1'b0;
            end
        end
    end

    // Registered status and pulse outputs.
    // These are derived from the *next* state/consumer/enable values. The
    // registered outputs therefore change on the same edge as the state they
    // describe, rather than one cycle later. Only the consumer group can be
    // RUNNING, so two groups can never report RUNNING together.
    always_comb begin
        next_busy   = (state_d == ST_START) || (state_d == ST_RUN);

        status_0_d  = STAT_IDLE;
        if (next_busy && (consumer_d == 1'b0)) begin
            status_0_d = STAT_RUNNING;
        end else if (reg_op_en_d[0]) begin
            status_0_d = STAT_PENDING;
        end

        status_1_d  = STAT_IDLE;
        if (next_busy && (consumer_d == 1'b1)) begin
            status_1_d = STAT_RUNNING;
        end else if (reg_op_en_d[1]) begin
            status_1_d = STAT_PENDING;
        end

        op_start_d  = (state_d == ST_START);

        done_intr_d = 2'b00;
        if (done_fire) begin
            done_intr_d = consumer_q ? 2'b10 : 2'b01;
        end
    end

    // State registers. Reset puts everything back to idle. That also drops a
    // layer that is in flight, so its completion can never be reported.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= ST_IDLE;
            consumer_q  <= 1'b0;
            reg_op_en_q <= 2'b00;
            status_0_q  <= STAT_IDLE;
            status_1_q  <= STAT_IDLE;
            op_start_q  <= 1'b0;
            done_intr_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            consumer_q  <= consumer_d;
            reg_op_en_q <= reg_op_en_d;
            status_0_q  <= status_0_d;
            status_1_q  <= status_1_d;
            op_start_q  <= op_start_d;
            done_intr_q <= done_intr_d;
        end
    end

    // op_grp follows consumer directly. consumer only flips on the dp_done
    // edge, so op_grp is stable for the whole START..RUN window.
    assign consumer  = consumer_q;
    assign op_grp    = consumer_q;
    assign status_0  = status_0_q;
    assign status_1  = status_1_q;
    assign reg_op_en = reg_op_en_q;
    assign op_start  = op_start_q;
    assign done_intr = done_intr_q;

endmodule

// File: tb/tb_nv_nvdla_csc_pp_status.sv
// ============================================================================
// tb_nv_nvdla_csc_pp_status
//
// Directed self-checking bench for nv_nvdla_csc_pp_status. Inputs are driven
// 1 time unit after each rising edge. Outputs are sampled at the same point,
// well away from the active edge. Every expected value is hand-computed from
// the ping-pong sequencing rules.
// ============================================================================
module tb_nv_nvdla_csc_pp_status;

    logic       nvdla_core_clk;
    logic       nvdla_core_rstn;
    logic       producer;
    logic       op_en_wr;
    logic       op_en_wr_data;
    logic       dp_done;
    logic       consumer;
    logic [1:0] status_0;
    logic [1:0] status_1;
    logic [1:0] reg_op_en;
    logic       op_start;
    logic       op_grp;
    logic [1:0] done_intr;

    int vectors;
    int miscompares;

    nv_nvdla_csc_pp_status dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .producer        (producer),
        .op_en_wr        (op_en_wr),
        .op_en_wr_data   (op_en_wr_data),
        .dp_done         (dp_done),
        .consumer        (consumer),
        .status_0        (status_0),
        .status_1        (status_1),
        .reg_op_en       (reg_op_en),
        .op_start        (op_start),
        .op_grp          (op_grp),
        .done_intr       (done_intr)
    );

    // 10-unit core clock.
    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    // Drive one cycle's worth of inputs, then advance one edge.
    task automatic applyStimulus(input logic prod, input logic wr,
                                 input logic wr_data, input logic done);
        producer      = prod;
        op_en_wr      = wr;
        op_en_wr_data = wr_data;
        dp_done       = done;
        step();
        op_en_wr      = 1'b0;
        op_en_wr_data = 1'b0;
        dp_done       = 1'b0;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare every output at once.
    task automatic checkAll(input string tag, input logic cons,
                            input logic [1:0] st0, input logic [1:0] st1,
                            input logic [1:0] en, input logic start,
                            input logic [1:0] intr);
        checkOutput({tag, ".consumer"},  8'(consumer),  8'(cons));
        checkOutput({tag, ".op_grp"},    8'(op_grp),    8'(cons));
        checkOutput({tag, ".status_0"},  8'(status_0),  8'(st0));
        checkOutput({tag, ".status_1"},  8'(status_1),  8'(st1));
        checkOutput({tag, ".reg_op_en"}, 8'(reg_op_en), 8'(en));
        checkOutput({tag, ".op_start"},  8'(op_start),  8'(start));
        checkOutput({tag, ".done_intr"}, 8'(done_intr), 8'(intr));
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        nvdla_core_rstn = 1'b0;
        producer        = 1'b0;
        op_en_wr        = 1'b0;
        op_en_wr_data   = 1'b0;
        dp_done         = 1'b0;
        $display("[TB] start");

        // Reset state
        step();
        step();
        checkAll("rst_held", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);
        nvdla_core_rstn = 1'b1;
        step();
        checkAll("rst_rel", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);

        // dp_done while idle is ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("idle_done", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);

        // Single layer on group 0
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("g0_en", 1'b0, 2'd2, 2'd0, 2'b01, 1'b0, 2'b00);
        step();
        checkAll("g0_start", 1'b0, 2'd1, 2'd0, 2'b01, 1'b1, 2'b00);
        step();
        checkAll("g0_run", 1'b0, 2'd1, 2'd0, 2'b01, 1'b0, 2'b00);
        // Clearing the running group is ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("g0_clr_ign", 1'b0, 2'd1, 2'd0, 2'b01, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("g0_done", 1'b1, 2'd0, 2'd0, 2'b00, 1'b0, 2'b01);
        step();
        checkAll("g0_after", 1'b1, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);

        // Ping-pong: group 1 runs, group 0 armed meanwhile
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkAll("pp_en1", 1'b1, 2'd0, 2'd2, 2'b10, 1'b0, 2'b00);
        step();
        checkAll("pp_start1", 1'b1, 2'd0, 2'd1, 2'b10, 1'b1, 2'b00);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("pp_en0", 1'b1, 2'd2, 2'd1, 2'b11, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("pp_done1", 1'b0, 2'd2, 2'd0, 2'b01, 1'b0, 2'b10);
        step();
        checkAll("pp_start0", 1'b0, 2'd1, 2'd0, 2'b01, 1'b1, 2'b00);
        step();
        checkAll("pp_run0", 1'b0, 2'd1, 2'd0, 2'b01, 1'b0, 2'b00);

        // Collision: set group 0 on the same edge as its completion
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkAll("coll", 1'b1, 2'd2, 2'd0, 2'b01, 1'b0, 2'b01);

        // Group 0 armed but consumer is 1: it must not start
        for (int i = 0; i < 5; i++) begin
            step();
            checkAll("ooo_wait", 1'b1, 2'd2, 2'd0, 2'b01, 1'b0, 2'b00);
        end

        // Arm group 1: it runs first, group 0 stays pending
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkAll("ooo_en1", 1'b1, 2'd2, 2'd2, 2'b11, 1'b0, 2'b00);
        step();
        checkAll("ooo_start1", 1'b1, 2'd2, 2'd1, 2'b11, 1'b1, 2'b00);
        // dp_done during START is ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkAll("start_done", 1'b1, 2'd2, 2'd1, 2'b11, 1'b0, 2'b00);
        step();
        checkAll("ooo_run1", 1'b1, 2'd2, 2'd1, 2'b11, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkAll("ooo_done1", 1'b0, 2'd2, 2'd0, 2'b01, 1'b0, 2'b10);
        step();
        checkAll("ooo_start0", 1'b0, 2'd1, 2'd0, 2'b01, 1'b1, 2'b00);
        step();
        checkAll("ooo_run0", 1'b0, 2'd1, 2'd0, 2'b01, 1'b0, 2'b00);

        // Asynchronous reset mid-layer
        nvdla_core_rstn = 1'b0;
        #1;
        checkAll("rst_async", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);
        step();
        nvdla_core_rstn = 1'b1;
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("rst_done_ign", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);
        step();
        checkAll("rst_quiet", 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
